// File: rtl/index_loader_pkg.sv
// Shared sizing constants and FSM state encoding for the index vector loader.
package index_loader_pkg;

    localparam int unsigned WORD_W     = 64;
    localparam int unsigned WORDS      = 14;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned VEC_W      = 896;
    localparam int unsigned MAX_CREDIT = 2;
    localparam int unsigned CREDIT_W   = 2;

    typedef enum logic [2:0] {
        StIdle,
        StWaitCredit,
        StIssue,
        StDrain,
        StPublish
    } state_e;

endpackage

// File: rtl/idx_credit_ctr.sv
// Saturating credit counter tracking free index registers in the controller.
module idx_credit_ctr
    import index_loader_pkg::*;
#(
    parameter int unsigned MaxCredit = MAX_CREDIT,
    parameter int unsigned CountW    = CREDIT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [CountW-1:0] count,
    output logic              sat_err
);

    localparam logic [CountW-1:0] CountMax = CountW'(MaxCredit);

    logic [CountW-1:0] count_q, count_d;
    logic              err_q, err_d;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (inc && !dec) begin
            // A release with every register already free means the controller lost track.
            if (count_q == CountMax) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + CountW'(1);
            end
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CountW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CountMax;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count   = count_q;
    assign sat_err = err_q;

endmodule

// File: rtl/index_vector_loader.sv
// Streams WORDS consecutive SRAM words into one index vector, gated by controller credit.
module index_vector_loader #(
    parameter int unsigned WORD_W = index_loader_pkg::WORD_W,
    parameter int unsigned WORDS  = index_loader_pkg::WORDS,
    parameter int unsigned ADDR_W = index_loader_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    consumed,
    output logic                    sram_rd_en,
    output logic [ADDR_W-1:0]       sram_rd_addr,
    input  logic [WORD_W-1:0]       sram_rd_data,
    output logic [WORDS*WORD_W-1:0] index_vector_buffer,
    output logic                    index_en,
    output logic                    busy,
    output logic                    credit_err
);
    import index_loader_pkg::*;

    localparam int unsigned CntW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CntW-1:0] LastWord = CntW'(WORDS - 1);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [CntW-1:0]         word_q, word_d;
    logic                    rd_valid_q;
    logic [CntW-1:0]         rd_idx_q;
    logic [WORDS*WORD_W-1:0] buf_q;
    logic [CREDIT_W-1:0]     credit;
    logic                    credit_ok;

    assign credit_ok = (credit != '0);

    idx_credit_ctr #(
        .MaxCredit(MAX_CREDIT),
        .CountW   (CREDIT_W)
    ) u_credit (
        .clk    (clk),
        .rst    (rst),
        .inc    (consumed),
        .dec    (index_en),
        .count  (credit),
        .sat_err(credit_err)
    );

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        word_d       = word_q;
        sram_rd_en   = 1'b0;
        sram_rd_addr = '0;
        index_en     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = base_addr;
                    word_d  = '0;
                    state_d = credit_ok ? StIssue : StWaitCredit;
                end
            end
            StWaitCredit: begin
                if (credit_ok) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                sram_rd_en   = 1'b1;
                // Address wraps naturally at 2^ADDR_W.
                sram_rd_addr = base_q + ADDR_W'(word_q);
                word_d       = word_q + CntW'(1);
                if (word_q == LastWord) begin
                    word_d  = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StPublish;
            end
            StPublish: begin
                index_en = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            word_q  <= word_d;
        end
    end

    // Read data lags the strobe by one cycle; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            buf_q      <= '0;
        end else begin
            rd_valid_q <= sram_rd_en;
            rd_idx_q   <= word_q;
            if (rd_valid_q) begin
                buf_q[WORD_W*rd_idx_q +: WORD_W] <= sram_rd_data;
            end
        end
    end

    assign index_vector_buffer = buf_q;
    assign busy                = (state_q != StIdle);

endmodule

// File: tb/tb_index_vector_loader.sv
// Directed bench for index_vector_loader with a one-cycle-latency SRAM model.
module tb_index_vector_loader;
    import index_loader_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic                 consumed;
    logic                 sram_rd_en;
    logic [ADDR_W-1:0]    sram_rd_addr;
    logic [WORD_W-1:0]    sram_rd_data;
    logic [VEC_W-1:0]     index_vector_buffer;
    logic                 index_en;
    logic                 busy;
    logic                 credit_err;

    int checks = 0;
    int errors = 0;

    logic [47:0]       tag;
    logic [ADDR_W-1:0] sram_base;

    always #5 clk = ~clk;

    index_vector_loader #(
        .WORD_W(WORD_W),
        .WORDS (WORDS),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .base_addr          (base_addr),
        .consumed           (consumed),
        .sram_rd_en         (sram_rd_en),
        .sram_rd_addr       (sram_rd_addr),
        .sram_rd_data       (sram_rd_data),
        .index_vector_buffer(index_vector_buffer),
        .index_en           (index_en),
        .busy               (busy),
        .credit_err         (credit_err)
    );

    // Word at address a of the current load holds {tag, a - base + 1}.
    always @(posedge clk) begin
        if (sram_rd_en) begin
            sram_rd_data <= {tag, 16'(sram_rd_addr - sram_base + 16'd1)};
        end else begin
            sram_rd_data <= 64'hDEAD_BEEF_0BAD_F00D;
        end
    end

    task automatic check(input string name, input logic [VEC_W-1:0] got,
                         input logic [VEC_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VEC_W-1:0] exp_vec(input logic [47:0] t);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int k = 0; k < WORDS; k++) begin
            v[WORD_W*k +: WORD_W] = {t, 16'(k + 1)};
        end
        return v;
    endfunction

    // Caller leaves the FSM one edge away from ISSUE; cycle numbering follows that edge.
    task automatic run_load(input logic [ADDR_W-1:0] base, input bit consume_pub,
                            input bit start_mid);
        logic [ADDR_W-1:0] exp_addr;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            step();
            start    = 1'b0;
            consumed = 1'b0;
            exp_addr = (cyc <= 14) ? 16'(base + 16'(cyc - 1)) : 16'h0000;
            check("rd_en", sram_rd_en, (cyc <= 14));
            check("rd_addr", sram_rd_addr, exp_addr);
            check("index_en", index_en, (cyc == 16));
            check("busy", busy, 1'b1);
            if (start_mid && cyc == 5) begin
                start     = 1'b1;
                base_addr = 16'h0F00;
            end
            if (consume_pub && cyc == 16) consumed = 1'b1;
        end
        check("buffer", index_vector_buffer, exp_vec(tag));
        step();
        consumed = 1'b0;
        check("idle_busy", busy, 1'b0);
        check("idle_index_en", index_en, 1'b0);
        check("idle_rd_en", sram_rd_en, 1'b0);
    endtask

    task automatic kick(input logic [ADDR_W-1:0] base, input logic [47:0] t);
        tag       = t;
        sram_base = base;
        base_addr = base;
        start     = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        consumed  = 1'b0;
        base_addr = '0;
        tag       = '0;
        sram_base = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_rd_en", sram_rd_en, 1'b0);
        check("rst_rd_addr", sram_rd_addr, '0);
        check("rst_index_en", index_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_credit_err", credit_err, 1'b0);
        check("rst_buffer", index_vector_buffer, '0);
        check("rst_credit", dut.credit, 2);

        // Basic load, credit 2 -> 1
        kick(16'h0100, 48'hA0A0_A0A0_A0A0);
        run_load(16'h0100, 1'b0, 1'b0);
        check("credit_after_a", dut.credit, 1);

        // Address wrap, credit 1 -> 0
        kick(16'hFFFA, 48'hB1B1_B1B1_B1B1);
        run_load(16'hFFFA, 1'b0, 1'b0);
        check("credit_after_b", dut.credit, 0);

        // Third request stalls with no credit
        kick(16'h0200, 48'hC2C2_C2C2_C2C2);
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wait_busy", busy, 1'b1);
            check("wait_rd_en", sram_rd_en, 1'b0);
            check("wait_rd_addr", sram_rd_addr, '0);
            check("wait_buffer_held", index_vector_buffer, exp_vec(48'hB1B1_B1B1_B1B1));
            step();
        end
        consumed = 1'b1;
        step();
        consumed = 1'b0;
        check("wait_credit_1", dut.credit, 1);
        check("wait_still_rd_en", sram_rd_en, 1'b0);
        // Consumed lands on PUBLISH: credit stays 1
        run_load(16'h0200, 1'b1, 1'b0);
        check("credit_pub_consume", dut.credit, 1);

        consumed = 1'b1;
        step();
        consumed = 1'b0;
        check("credit_to_2", dut.credit, 2);
        check("no_err_yet", credit_err, 1'b0);
        consumed = 1'b1;
        step();
        consumed = 1'b0;
        check("credit_sat", dut.credit, 2);
        check("err_set", credit_err, 1'b1);
        step();
        step();
        step();
        check("err_sticky", credit_err, 1'b1);

        // Start pulsed during ISSUE is ignored
        kick(16'h0300, 48'hD3D3_D3D3_D3D3);
        run_load(16'h0300, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_requeue_busy", busy, 1'b0);
            check("no_requeue_rd_en", sram_rd_en, 1'b0);
            check("no_requeue_index_en", index_en, 1'b0);
        end
        check("credit_after_d", dut.credit, 1);

        // Reset in the middle of ISSUE
        kick(16'h0400, 48'hE4E4_E4E4_E4E4);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            step();
            start = 1'b0;
            check("abort_rd_en", sram_rd_en, 1'b1);
            check("abort_rd_addr", sram_rd_addr, 16'(16'h0400 + 16'(cyc - 1)));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_rd_en_off", sram_rd_en, 1'b0);
        check("abort_rd_addr_zero", sram_rd_addr, '0);
        check("abort_buffer", index_vector_buffer, '0);
        check("abort_credit", dut.credit, 2);
        check("abort_err_clear", credit_err, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("abort_no_index_en", index_en, 1'b0);
            step();
        end
        check("abort_buffer_still_zero", index_vector_buffer, '0);

        // Normal load after abort
        kick(16'h0500, 48'hF5F5_F5F5_F5F5);
        run_load(16'h0500, 1'b0, 1'b0);
        check("credit_after_f", dut.credit, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
